// File: rtl/duck_pkg.sv
// Shared game-state encodings, shot FSM state type and coordinate helpers
// for the duck-hunt pipeline.
package duck_pkg;

    localparam int COORD_W = 10;

    localparam logic [1:0] GS_IDLE      = 2'd0;
    localparam logic [1:0] GS_PLAY      = 2'd1;
    localparam logic [1:0] GS_ROUND_END = 2'd2;
    localparam logic [1:0] GS_OVER      = 2'd3;

    typedef enum logic [2:0] {
        ARMED = 3'd0,
        EVAL  = 3'd1,
        HIT   = 3'd2,
        MISS  = 3'd3,
        EMPTY = 3'd4
    } shot_state_t;

    // One extra bit keeps the difference exact, so |a-b| never wraps.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[COORD_W] ? (COORD_W+1)'(-d) : (COORD_W+1)'(d);
    endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Synchronises a raw button, debounces it and emits a one-cycle pulse on the
// debounced rising edge. Reusable for any mechanical push-button.
module trigger_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic trigger,
    output logic fire
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             trig_s;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flip;

    assign trig_s = sync_q[1];
    assign flip   = (trig_s != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            fire    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], trigger};
            fire   <= flip && trig_s;
            if (trig_s == level_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                level_q <= trig_s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shot_detector.sv
// Turns the gun trigger into rate-limited shots, tests them against the bird
// box and drives bird_shot / muzzle_flash holds plus per-round ammo.
//
//   state | meaning
//   ARMED | waiting for an accepted fire
//   EVAL  | captured coordinates are being compared against the bird box
//   HIT   | bird_shot and muzzle_flash held for HOLD_CYCLES
//   MISS  | muzzle_flash only, held for HOLD_CYCLES
//   EMPTY | no ammo left; only new_round leaves
module shot_detector
    import duck_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BIRD_HALF_W     = 16,
    parameter int BIRD_HALF_H     = 16,
    parameter int AMMO            = 3,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               trigger,
    input  logic [1:0]         state,
    input  logic               new_round,
    input  logic [COORD_W-1:0] cross_x,
    input  logic [COORD_W-1:0] cross_y,
    input  logic [COORD_W-1:0] bird_x,
    input  logic [COORD_W-1:0] bird_y,
    input  logic               bird_alive,
    output logic               bird_shot,
    output logic               muzzle_flash,
    output logic [1:0]         shots_left,
    output logic               out_of_ammo
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]         AMMO_INIT = 2'(AMMO);
    localparam logic [COORD_W:0]   HALF_W    = (COORD_W+1)'(BIRD_HALF_W);
    localparam logic [COORD_W:0]   HALF_H    = (COORD_W+1)'(BIRD_HALF_H);

    shot_state_t        shot_st, shot_nx;
    logic               fire;
    logic               accept;
    logic               hit;
    logic               bird_shot_d, muzzle_flash_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [COORD_W-1:0] cap_cx, cap_cy, cap_bx, cap_by;
    logic               cap_alive;

    trigger_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .trigger (trigger),
        .fire    (fire)
    );

    assign accept = (shot_st == ARMED) && fire && (state == GS_PLAY)
                    && (shots_left != 2'd0) && !new_round;

    assign hit = cap_alive
                 && (abs_diff(cap_cx, cap_bx) <= HALF_W)
                 && (abs_diff(cap_cy, cap_by) <= HALF_H);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) shot_st <= ARMED;
        else          shot_st <= shot_nx;
    end

    always_comb begin
        shot_nx = shot_st;
        if (new_round) begin
            shot_nx = ARMED;
        end else begin
            case (shot_st)
                ARMED:    if (accept) shot_nx = EVAL;
                EVAL:     shot_nx = hit ? HIT : MISS;
                HIT, MISS:
                    if (hold_q == '0) shot_nx = (shots_left == 2'd0) ? EMPTY : ARMED;
                EMPTY:    shot_nx = EMPTY;
                default:  shot_nx = ARMED;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they are
    // high exactly while the FSM sits in HIT/MISS.
    always_comb begin
        bird_shot_d    = (shot_nx == HIT);
        muzzle_flash_d = (shot_nx == HIT) || (shot_nx == MISS);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bird_shot    <= 1'b0;
            muzzle_flash <= 1'b0;
            shots_left   <= AMMO_INIT;
            hold_q       <= '0;
            cap_cx       <= '0;
            cap_cy       <= '0;
            cap_bx       <= '0;
            cap_by       <= '0;
            cap_alive    <= 1'b0;
        end else begin
            bird_shot    <= bird_shot_d;
            muzzle_flash <= muzzle_flash_d;
            if (new_round) begin
                shots_left <= AMMO_INIT;
            end else if (accept) begin
                shots_left <= shots_left - 2'd1;
                cap_cx     <= cross_x;
                cap_cy     <= cross_y;
                cap_bx     <= bird_x;
                cap_by     <= bird_y;
                cap_alive  <= bird_alive;
            end
            if (shot_st == EVAL)
                hold_q <= HOLD_LOAD;
            else if ((shot_st == HIT || shot_st == MISS) && hold_q != '0)
                hold_q <= hold_q - 1'b1;
        end
    end

    assign out_of_ammo = (shots_left == 2'd0);

endmodule
